float_alu_core: RTL and testbench

Multi-cycle IEEE-754 binary32 add/subtract unit with a start/valid handshake. It sits beside the integer datapath as the FP arithmetic execution block. It accepts one operation at a time, handles special values and subnormals in full, and returns the rounded result plus an exception-flag vector.

---
 rtl/float_alu_core.sv | 256 +++++++++++++++++++++++++
 tb/tb_float_alu_core.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/float_alu_core.sv
// Multi-cycle IEEE-754 binary32 add/subtract unit with a start/valid handshake.
// One operation in flight; fixed 4-clock latency from start to valid_out.
module float_alu_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  op_code,
    input  logic        round_mode,
    input  logic        start,
    output logic [31:0] result,
    output logic        valid_out,
    output logic [4:0]  flags
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM_ROUND
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t state, state_nxt;

    // captured request
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    logic        rm_q;

    // unpacked operands and special-case outcome
    logic        sa_q, sb_q;
    logic [9:0]  ea_q, eb_q;
    logic [23:0] ma_q, mb_q;
    logic        spec_q, spec_nv_q;
    logic [31:0] spec_res_q;

    // aligned operands
    logic        sl_q, effsub_q;
    logic [9:0]  el_q;
    logic [26:0] ml_q, ms_q;

    // raw sum
    logic [27:0] sum_q;

    // ---------------- unpack logic ----------------
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic        sb_eff;
    logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic        u_spec, u_nv;
    logic [31:0] u_res;

    always_comb begin
        a_exp  = a_q[30:23];
        b_exp  = b_q[30:23];
        a_frac = a_q[22:0];
        b_frac = b_q[22:0];
        sb_eff = b_q[31] ^ (op_q == 3'b001);
        a_nan  = (&a_exp) & (|a_frac);
        b_nan  = (&b_exp) & (|b_frac);
        a_snan = a_nan & ~a_frac[22];
        b_snan = b_nan & ~b_frac[22];
        a_inf  = (&a_exp) & ~(|a_frac);
        b_inf  = (&b_exp) & ~(|b_frac);

        u_spec = 1'b1;
        u_nv   = 1'b0;
        u_res  = QNAN;
        if (op_q != 3'b000 && op_q != 3'b001) begin
            u_nv = 1'b1;
        end else if (a_nan || b_nan) begin
            u_nv = a_snan | b_snan;
        end else if (a_inf && b_inf) begin
            if (a_q[31] == sb_eff)
                u_res = {a_q[31], 8'hFF, 23'd0};
            else
                u_nv = 1'b1;
        end else if (a_inf) begin
            u_res = {a_q[31], 8'hFF, 23'd0};
        end else if (b_inf) begin
            u_res = {sb_eff, 8'hFF, 23'd0};
        end else begin
            u_spec = 1'b0;
        end
    end

    // ---------------- align logic ----------------
    logic        a_ge;
    logic [9:0]  e_big, e_small, e_diff;
    logic [23:0] m_big, m_small;
    logic [4:0]  al_sh;
    logic [26:0] small_ext, small_shr;
    logic        al_lost;

    always_comb begin
        a_ge    = {ea_q, ma_q} >= {eb_q, mb_q};
        e_big   = a_ge ? ea_q : eb_q;
        e_small = a_ge ? eb_q : ea_q;
        m_big   = a_ge ? ma_q : mb_q;
        m_small = a_ge ? mb_q : ma_q;
        e_diff  = e_big - e_small;
        al_sh   = (e_diff > 10'd26) ? 5'd26 : e_diff[4:0];
        small_ext = {m_small, 3'b000};
        small_shr = small_ext >> al_sh;
        // everything pushed past the sticky position folds into sticky
        al_lost   = |(small_ext & ((27'd1 << al_sh) - 27'd1));
    end

    // ---------------- normalise / round logic ----------------
    logic [4:0]  lz;
    logic [9:0]  lim, nsh;
    logic [26:0] n_sig;
    logic [9:0]  n_exp, exp_f;
    logic [23:0] mant, mant_f;
    logic [24:0] mant_r;
    logic        g, r, s, inexact, rnd_up, ovf;
    logic [7:0]  exp_field;
    logic [31:0] nr_res;
    logic [4:0]  nr_flags;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int unsigned i = 0; i < 27; i++)
            if (v[i]) n = 5'(26 - i);
        return n;
    endfunction

    always_comb begin
        lz    = lzc27(sum_q[26:0]);
        lim   = el_q - 10'd1;
        nsh   = '0;
        n_sig = '0;
        n_exp = el_q;
        if (sum_q[27]) begin
            n_sig = {sum_q[27:2], sum_q[1] | sum_q[0]};
            n_exp = el_q + 10'd1;
        end else begin
            // stop at exponent 1; whatever is left unnormalised is subnormal
            nsh   = ({5'd0, lz} > lim) ? lim : {5'd0, lz};
            n_sig = sum_q[26:0] << nsh;
            n_exp = el_q - nsh;
        end

        mant    = n_sig[26:3];
        g       = n_sig[2];
        r       = n_sig[1];
        s       = n_sig[0];
        inexact = g | r | s;
        rnd_up  = ~rm_q & g & (r | s | mant[0]);
        mant_r  = {1'b0, mant} + {24'd0, rnd_up};
        if (mant_r[24]) begin
            mant_f = mant_r[24:1];
            exp_f  = n_exp + 10'd1;
        end else begin
            mant_f = mant_r[23:0];
            exp_f  = n_exp;
        end
        ovf       = mant_f[23] & (exp_f >= 10'd255);
        exp_field = mant_f[23] ? exp_f[7:0] : 8'd0;

        nr_res   = {sl_q, exp_field, mant_f[22:0]};
        nr_flags = {3'b000, (exp_field == 8'd0) & inexact, inexact};
        if (spec_q) begin
            nr_res   = spec_res_q;
            nr_flags = {spec_nv_q, 4'b0000};
        end else if (sum_q == 28'd0) begin
            nr_res   = {sl_q & ~effsub_q, 31'd0};
            nr_flags = '0;
        end else if (ovf) begin
            nr_res   = rm_q ? {sl_q, 31'h7F7F_FFFF} : {sl_q, 8'hFF, 23'd0};
            nr_flags = 5'b00101;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (start) state_nxt = S_UNPACK;
            S_UNPACK:     state_nxt = S_ALIGN;
            S_ALIGN:      state_nxt = S_ADD;
            S_ADD:        state_nxt = S_NORM_ROUND;
            S_NORM_ROUND: state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0; b_q <= '0; op_q <= '0; rm_q <= 1'b0;
            sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0;
            ma_q <= '0; mb_q <= '0;
            spec_q <= 1'b0; spec_nv_q <= 1'b0; spec_res_q <= '0;
            sl_q <= 1'b0; effsub_q <= 1'b0; el_q <= '0;
            ml_q <= '0; ms_q <= '0; sum_q <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_q  <= op_a;
                    b_q  <= op_b;
                    op_q <= op_code;
                    rm_q <= round_mode;
                end
                S_UNPACK: begin
                    sa_q <= a_q[31];
                    sb_q <= sb_eff;
                    ea_q <= (a_exp == 8'd0) ? 10'd1 : {2'b00, a_exp};
                    eb_q <= (b_exp == 8'd0) ? 10'd1 : {2'b00, b_exp};
                    ma_q <= {a_exp != 8'd0, a_frac};
                    mb_q <= {b_exp != 8'd0, b_frac};
                    spec_q     <= u_spec;
                    spec_nv_q  <= u_nv;
                    spec_res_q <= u_res;
                end
                S_ALIGN: begin
                    sl_q     <= a_ge ? sa_q : sb_q;
                    effsub_q <= sa_q ^ sb_q;
                    el_q     <= e_big;
                    ml_q     <= {m_big, 3'b000};
                    ms_q     <= {small_shr[26:1], small_shr[0] | al_lost};
                end
                S_ADD: begin
                    sum_q <= effsub_q ? ({1'b0, ml_q} - {1'b0, ms_q})
                                      : ({1'b0, ml_q} + {1'b0, ms_q});
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= '0;
            flags     <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= (state == S_NORM_ROUND);
            if (state == S_NORM_ROUND) begin
                result <= nr_res;
                flags  <= nr_flags;
            end
        end
    end

endmodule

// File: tb/tb_float_alu_core.sv
// Directed-vector bench for float_alu_core: hand-computed results, flags,
// latency, handshake control and reset behaviour.
module tb_float_alu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b;
    logic [2:0]  op_code;
    logic        round_mode;
    logic        start;
    logic [31:0] result;
    logic        valid_out;
    logic [4:0]  flags;

    int n_checks = 0;
    int n_errors = 0;

    float_alu_core dut (
        .clk        (clk),
        .rst        (rst),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_code    (op_code),
        .round_mode (round_mode),
        .start      (start),
        .result     (result),
        .valid_out  (valid_out),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic rm);
        op_a = a; op_b = b; op_code = op; round_mode = rm;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!valid_out && lat < 12);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic rm,
                       input logic [31:0] exp_res, input logic [4:0] exp_flg);
        int lat;
        launch(a, b, op, rm);
        wait_valid(lat);
        check({tag, " latency"}, lat, 4);
        check({tag, " result"}, result, exp_res);
        check({tag, " flags"}, {27'd0, flags}, {27'd0, exp_flg});
    endtask

    task automatic count_valid(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (valid_out) n++;
        end
    endtask

    initial begin
        int lat, nv;
        rst = 1'b0; start = 1'b0;
        op_a = '0; op_b = '0; op_code = '0; round_mode = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset result", result, 32'h0);
        check("reset flags", {27'd0, flags}, 32'h0);
        check("reset valid", {31'd0, valid_out}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // normal RNE add/sub
        run("add1",  32'h41A60000, 32'h40100000, 3'b000, 1'b0, 32'h41B80000, 5'h00);
        run("add2",  32'h41020000, 32'hC1040000, 3'b000, 1'b0, 32'hBE000000, 5'h00);
        run("add3",  32'h41600000, 32'hC1440000, 3'b000, 1'b0, 32'h3FE00000, 5'h00);
        run("b2b1",  32'h40A80000, 32'h41940000, 3'b000, 1'b0, 32'h41BE0000, 5'h00);
        run("b2b2",  32'h40A80000, 32'h41940000, 3'b000, 1'b0, 32'h41BE0000, 5'h00);
        run("sub1",  32'h41B80000, 32'h40100000, 3'b001, 1'b0, 32'h41A60000, 5'h00);

        // zero signs
        run("z++",   32'h00000000, 32'h00000000, 3'b000, 1'b0, 32'h00000000, 5'h00);
        run("z+-",   32'h00000000, 32'h80000000, 3'b000, 1'b0, 32'h00000000, 5'h00);
        run("z-+",   32'h80000000, 32'h00000000, 3'b000, 1'b0, 32'h00000000, 5'h00);
        run("z--",   32'h80000000, 32'h80000000, 3'b000, 1'b0, 32'h80000000, 5'h00);
        run("cancel",32'h3F800000, 32'h3F800000, 3'b001, 1'b0, 32'h00000000, 5'h00);
        run("cnlrtz",32'h3F800000, 32'h3F800000, 3'b001, 1'b1, 32'h00000000, 5'h00);

        // subnormal
        run("subn",  32'h00000002, 32'h00000002, 3'b000, 1'b0, 32'h00000004, 5'h00);

        // specials
        run("infinf",32'h7F800000, 32'h7F800000, 3'b000, 1'b0, 32'h7F800000, 5'h00);
        run("infsub",32'h7F800000, 32'hFF800000, 3'b000, 1'b0, 32'h7FC00000, 5'h10);
        run("snan",  32'h7F800001, 32'h3F800000, 3'b000, 1'b0, 32'h7FC00000, 5'h10);
        run("qnan",  32'h7FC00001, 32'h3F800000, 3'b000, 1'b0, 32'h7FC00000, 5'h00);
        run("inffin",32'h3F800000, 32'hFF800000, 3'b000, 1'b0, 32'hFF800000, 5'h00);

        // rounding and overflow
        run("ovfrne",32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 1'b0, 32'h7F800000, 5'h05);
        run("ovfrtz",32'h7F7FFFFF, 32'h7F7FFFFF, 3'b000, 1'b1, 32'h7F7FFFFF, 5'h05);
        run("tie",   32'h3F800000, 32'h33800000, 3'b000, 1'b0, 32'h3F800000, 5'h01);
        run("uprne", 32'h3F800000, 32'h33800001, 3'b000, 1'b0, 32'h3F800001, 5'h01);
        run("uprtz", 32'h3F800000, 32'h33800001, 3'b000, 1'b1, 32'h3F800000, 5'h01);

        // valid_out is a single-cycle pulse
        @(posedge clk); #1;
        check("pulse width", {31'd0, valid_out}, 32'h0);

        // start while busy is ignored; inputs change after capture
        launch(32'h41A60000, 32'h40100000, 3'b000, 1'b0);
        @(posedge clk); #1;
        op_a = 32'h7F800000; op_b = 32'h7F800000; op_code = 3'b011;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_valid(lat);
        check("busy latency", lat, 2);
        check("busy result", result, 32'h41B80000);
        count_valid(8, nv);
        check("busy extra valid", nv, 0);

        // reset in the middle of an operation
        launch(32'h41600000, 32'hC1440000, 3'b000, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst result", result, 32'h0);
        check("midrst flags", {27'd0, flags}, 32'h0);
        check("midrst valid", {31'd0, valid_out}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        count_valid(8, nv);
        check("midrst no valid", nv, 0);

        // reserved op code
        run("resv",  32'h3F800000, 32'h3F800000, 3'b011, 1'b0, 32'h7FC00000, 5'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
